// File: rtl/seven_seg_pkg.sv
// Shared types, segment constants and BCD-to-segment decode for the
// multiplexed common-anode 7-segment scanner.
package seven_seg_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;

  // Active-low {g,f,e,d,c,b,a}; any non-decimal code renders as a dash.
  function automatic seg_t bcd_to_seg(input bcd_t bcd);
    seg_t seg;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_scan_prescaler.sv
// Digit-slot prescaler: counts 0..SCAN_DIV-1 and flags the last cycle of
// each slot so the scanner can step to the next digit.
module scan_prescaler
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed 7-segment scanner: snapshots the BCD vector once per frame and
// drives one active-low digit per slot with blanking, dash and decimal points.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DIGITS-1:0][3:0] bcdin,
  input  logic [DIGITS-1:0]      dpin,
  input  logic                   blank,
  output logic [DIGITS-1:0]      an,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic                   frame
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic tick;

  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   load_pending_q, load_pending_d;
  logic [DIGITS-1:0][3:0] snap_q, snap_d;
  logic [DIGITS-1:0]      dp_snap_q, dp_snap_d;
  logic [DIGITS-1:0]      an_q, an_d;
  seg_t                   seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic                   frame_q, frame_d;

  logic                   load;
  logic                   zero_run;
  logic [DIGITS-1:0]      blank_mask;
  bcd_t                   digit;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Outputs decode the post-edge index and snapshot so the pins never lag.
  always_comb begin
    load           = load_pending_q || (tick && (idx_q == IDX_LAST));
    load_pending_d = load_pending_q && !load;
    snap_d         = load ? bcdin : snap_q;
    dp_snap_d      = load ? dpin  : dp_snap_q;

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // A digit blanks only if it and everything above it is zero; digit 0 never.
    zero_run   = blank;
    blank_mask = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run && (snap_d[i] == 4'd0);
      blank_mask[i] = zero_run;
    end

    digit   = snap_d[idx_d];
    seg_d   = blank_mask[idx_d] ? SEG_BLANK : bcd_to_seg(digit);
    an_d    = ~(DIGITS'(1) << idx_d);
    dp_d    = ~dp_snap_d[idx_d];
    frame_d = load;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q          <= '0;
      load_pending_q <= 1'b1;
      snap_q         <= '0;
      dp_snap_q      <= '0;
      an_q           <= '1;
      seg_q          <= SEG_BLANK;
      dp_q           <= 1'b1;
      frame_q        <= 1'b0;
    end else begin
      idx_q          <= idx_d;
      load_pending_q <= load_pending_d;
      snap_q         <= snap_d;
      dp_snap_q      <= dp_snap_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      frame_q        <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (DIGITS=4, SCAN_DIV=4): directed
// frames push expected per-cycle pin values; a negedge monitor pops and compares.
module tb_seven_seg_scanner;

  logic            clock = 1'b0;
  logic            reset;
  logic [3:0][3:0] bcdin;
  logic [3:0]      dpin;
  logic            blank;
  logic [3:0]      an;
  logic [6:0]      seg;
  logic            dp;
  logic            frame;

  seven_seg_scanner #(
    .DIGITS   (4),
    .SCAN_DIV (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bcdin (bcdin),
    .dpin  (dpin),
    .blank (blank),
    .an    (an),
    .seg   (seg),
    .dp    (dp),
    .frame (frame)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    string      nm;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s missed at cyc=%0d (now %0d)", e.nm, e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      n_cmp++;
      if ({an, seg, dp, frame} !== {e.an, e.seg, e.dp, e.frame}) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got an=%b seg=%h dp=%b frame=%b required an=%b seg=%h dp=%b frame=%b",
                 e.nm, cyc, an, seg, dp, frame, e.an, e.seg, e.dp, e.frame);
      end
    end
  end

  task automatic push_reset(input string nm, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.cyc = first + k; e.nm = nm;
      e.an = 4'b1111; e.seg = 7'h7F; e.dp = 1'b1; e.frame = 1'b0;
      q.push_back(e);
    end
  endtask

  // segs = {digit3, digit2, digit1, digit0}; short_f marks the first frame
  // after reset, whose digit-0 slot is one cycle shorter.
  task automatic push_frame(input string nm, input int start, input bit short_f,
                            input logic [27:0] segs, input logic [3:0] dpm,
                            input int lim);
    for (int s = 0; s < 4; s++) begin
      int first;
      int len;
      first = (s == 0) ? start : (short_f ? start + 4 * s - 1 : start + 4 * s);
      len   = (s == 0 && short_f) ? 3 : 4;
      for (int k = 0; k < len; k++) begin
        if (first + k <= lim) begin
          exp_t e;
          e.cyc   = first + k;
          e.nm    = nm;
          e.an    = ~(4'b0001 << s);
          e.seg   = segs[7 * s +: 7];
          e.dp    = ~dpm[s];
          e.frame = (s == 0 && k == 0);
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  localparam logic [27:0] SEGS_1024 = {7'h79, 7'h40, 7'h24, 7'h19};
  localparam int          NOLIM     = 1000000;

  initial begin
    reset = 1'b1;
    bcdin = {4'd1, 4'd0, 4'd2, 4'd4};
    dpin  = 4'b0100;
    blank = 1'b0;
    push_reset("reset_init", 1, 3);

    wait_cyc(3);
    reset = 1'b0;
    push_frame("scan1024_f0", 4, 1'b1, SEGS_1024, 4'b0100, NOLIM);
    push_frame("scan1024_f1", 19, 1'b0, SEGS_1024, 4'b0100, NOLIM);
    push_frame("scan1024_f2", 35, 1'b0, SEGS_1024, 4'b0100, 39);

    wait_cyc(39);
    reset = 1'b1;
    push_reset("reset_mid", 40, 3);

    wait_cyc(42);
    reset = 1'b0;
    push_frame("rst_release_f0", 43, 1'b1, SEGS_1024, 4'b0100, NOLIM);
    push_frame("rst_release_f1", 58, 1'b0, SEGS_1024, 4'b0100, NOLIM);

    wait_cyc(73);
    blank = 1'b1;
    bcdin = {4'd0, 4'd0, 4'd0, 4'd7};
    dpin  = 4'b0000;
    push_frame("blank_0007", 74, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b0000, NOLIM);

    wait_cyc(89);
    bcdin = {4'd0, 4'd0, 4'd0, 4'd0};
    push_frame("blank_0000", 90, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000, NOLIM);

    wait_cyc(105);
    bcdin = {4'd0, 4'd3, 4'd0, 4'd0};
    push_frame("blank_0300", 106, 1'b0, {7'h7F, 7'h30, 7'h40, 7'h40}, 4'b0000, NOLIM);

    wait_cyc(121);
    bcdin = {4'd0, 4'd0, 4'd12, 4'd5};
    push_frame("invalid_dash", 122, 1'b0, {7'h7F, 7'h7F, 7'h3F, 7'h12}, 4'b0000, NOLIM);

    wait_cyc(137);
    bcdin = {4'd0, 4'd0, 4'd0, 4'd1};
    dpin  = 4'b0010;
    push_frame("snap_hold", 138, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h79}, 4'b0010, NOLIM);
    push_frame("snap_update", 154, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h10}, 4'b0010, NOLIM);

    wait_cyc(142);
    bcdin = {4'd0, 4'd0, 4'd0, 4'd9};

    wait_cyc(172);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout at cyc=%0d, required finish by cyc=172", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Downstream display stage: takes the per-digit BCD vector produced by the binary-to-BCD converter and drives a multiplexed common-anode 7-segment display, one digit per scan slot.
- Snapshots the BCD input once per frame, so digits never tear while the counter is changing.
- Provides leading-zero blanking, a dash for invalid codes, per-digit decimal points, and a frame-start strobe.

Parameters:
DIGITS, 4, number of display digits and BCD nibbles (index 0 = least significant).
SCAN_DIV, 50000, clock cycles each digit stays lit; legal range ≥2.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
bcdin  input  [DIGITS-1:0][3:0]  BCD digits; bcdin[0] = ones.
dpin  input  DIGITS  decimal point request per digit; 1 = lit.
blank  input  1  1 = suppress leading zeros.
an  output  DIGITS  anode enables, active-low, one-hot-zero.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
dp  output  1  decimal point, active-low.
frame  output  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (synchronous, active-high). Clears the prescaler count, idx, the snapshot registers and the dp snapshot. Sets an = all 1, seg = 7'h7F, dp = 1, frame = 0, and sets the load_pending flag.
- Reset asserted mid-frame behaves identically; there is no partial-frame carry-over.
- Prescaler: cnt counts 0..SCAN_DIV-1. tick = (cnt == SCAN_DIV-1), and cnt wraps to 0 on that cycle.
- Digit index: idx advances on tick, 0 → 1 → … → DIGITS-1 → 0.
- Snapshot load:
  - Loads bcdin and dpin when load_pending = 1, or when tick && idx == DIGITS-1.
  - frame = 1 in exactly the cycle following that edge.
  - load_pending clears on its first load, so the first edge after reset deassertion loads and shows digit 0.
- Output timing:
  - an, seg and dp are registered. Each edge loads them from the decode of the post-edge idx and snapshot, so there is zero lag between internal state and pins.
  - an[idx] = 0; all other bits = 1.
- Segment decode (active-low, gfedcba):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10.
  - Codes 10–15 = 3F (dash).
  - Blanked digit = 7F.
- Blanking: with blank = 1, digit i > 0 shows 7F when snapshot digits i..DIGITS-1 are all 0.
  - Digit 0 is never blanked, so all-zero displays "0".
  - The anode still scans blanked digits, keeping constant duty.
  - An invalid code counts as non-zero for blanking.
- dp = ~dp_snapshot[idx]. It is not suppressed by blanking.
- bcdin and dpin changes between snapshots have no visible effect.
- blank is sampled live each cycle, not snapshotted.

Decomposition:
- Package seven_seg_pkg holds:
  - typedef bcd_t (logic [3:0]);
  - typedef seg_t (logic [6:0]);
  - constants SEG_BLANK = 7'h7F and SEG_DASH = 7'h3F;
  - function bcd_to_seg(bcd_t) returning active-low seg_t.
- One sub-module, scan_prescaler. It holds cnt and issues tick, parameterised by SCAN_DIV, with synchronous reset.
- Snapshot, index, blanking and output registers stay in the top module.

Test Plan (DIGITS=4, SCAN_DIV=4):
- Reset: hold reset 3 cycles mid-scan → an = 1111, seg = 7F, dp = 1, frame = 0 throughout. First edge after release → an = 1110, frame = 1 the following cycle.
- Scan of 1024: bcdin = {1,0,2,4}, blank = 0. Each digit lights for exactly 4 cycles:
  - an = 1110 with seg = 19;
  - an = 1101 with seg = 24;
  - an = 1011 with seg = 40;
  - an = 0111 with seg = 79.
  - frame pulses every 16 cycles.
- Leading-zero blanking: blank = 1, bcdin = {0,0,0,7} → digit0 seg = 78, digits 1–3 seg = 7F with an still stepping. Then bcdin = {0,0,0,0} → digit0 = 40, others 7F. Then bcdin = {0,3,0,0} → digits 0–2 = 40,40,30; digit3 = 7F.
- Invalid code: bcdin = {0,0,12,5}, blank = 1 → digit1 seg = 3F, digit0 seg = 12, digits 2–3 blank.
- Snapshot isolation: change bcdin from {0,0,0,1} to {0,0,0,9} while idx = 1 → digit0 keeps showing 79 until after the next frame pulse, then shows 10.
- Decimal point: dpin = 0100 → dp = 0 only while an = 1011; dp = 1 in all other slots and during reset.
